ecc_secded_pipe: RTL and testbench
==================================

# ecc_secded_pipe

Parametrised, pipelined SECDED (single-error-correct, double-error-detect) Hamming codec for FIFO and RAM word protection in the sync-aggregation datapath. Replaces fixed-width combinational ECC with:
- a registered encoder with test error injection;
- a 2-stage valid/ready decoder carrying a per-word tag;
- saturating error counters and a sticky first-error log for software.

## Interface
- DATA_WIDTH, 64: protected data bits, 8..247.
- TAG_WIDTH, 10: sideband tag (typically RAM address) carried through the decoder.
- CNT_WIDTH, 16: error counter width.
- PARITY_WIDTH (localparam): R+1, where R is the smallest integer with 2^R >= DATA_WIDTH+R+1. Equals 8 for 64.
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bypass  in  1  quasi-static; 1 = decoder passes data, flags 0, nothing counted.
- enc_in_valid  in  1  encode request.
- enc_in_data  in  DATA_WIDTH  data to encode.
- enc_inj_mask  in  DATA_WIDTH+PARITY_WIDTH  XORed onto {parity,data} after encode (test injection).
- enc_out_valid  out  1  encoded word valid.
- enc_out_data  out  DATA_WIDTH  encoded data.
- enc_out_parity  out  PARITY_WIDTH  check bits.
- dec_in_valid / dec_in_ready  in / out  1  decoder input handshake.
- dec_in_data  in  DATA_WIDTH; dec_in_parity  in  PARITY_WIDTH; dec_in_tag  in  TAG_WIDTH.
- dec_out_valid / dec_out_ready  out / in  1  decoder output handshake.
- dec_out_data  out  DATA_WIDTH  corrected data.
- dec_out_tag  out  TAG_WIDTH.
- dec_out_sbit, dec_out_dbit  out  1  corrected single error / uncorrectable error.
- sbit_cnt, dbit_cnt  out  CNT_WIDTH  saturating event counts.
- err_log_valid  out  1; err_log_dbit  out  1; err_log_tag  out  TAG_WIDTH; err_log_syn  out  PARITY_WIDTH.
- cnt_clr  in  1  synchronous clear of counters and log.

## Operation
- Code layout:
  - Codeword positions run 1..DATA_WIDTH+R. Power-of-two positions hold check bits parity[0..R-1].
  - Data bits fill the remaining positions in ascending order; data[0] is at position 3.
  - parity[i] = XOR of data bits whose position has bit i set.
  - parity[R] = XOR of all data bits and parity[R-1:0], giving even overall parity.
- Syndrome: s_h = recomputed parity[R-1:0] XOR received; s_p = XOR of the whole received word.
- Classification:
  - s_h=0, s_p=0: clean.
  - s_p=1, s_h=0: overall-parity bit error. Flag sbit; data unchanged.
  - s_p=1, s_h a power of two: check-bit error. Flag sbit; data unchanged.
  - s_p=1, s_h a data position: flip that data bit; flag sbit.
  - s_p=1, s_h > DATA_WIDTH+R: flag dbit.
  - s_p=0, s_h != 0: flag dbit; data passed uncorrected.
- Decoder stages:
  - S1 registers data, tag, syndrome and bypass.
  - S2 registers corrected data and flags.
- Counting and logging occur only on an output handshake (dec_out_valid & dec_out_ready) and never in bypass. This prevents double counting under stall.
- Counters increment by 1 and saturate at all-ones.
- Log behaviour:
  - The log captures tag, syndrome {s_p,s_h} and dbit on the first error after reset or clear, then sets err_log_valid.
  - A later dbit overwrites a held sbit entry once; a held dbit entry is never overwritten.
- Clear/event collision: cnt_clr together with an error handshake applies clear first, then the event. Result: count=1 and log loaded with that event.

## Timing
- Reset values: all valids 0; dec_in_ready 1; data, parity, tag, flags, counters and log outputs 0.
- Encoder:
  - Latency 1 cycle; no backpressure.
  - enc_out_valid follows enc_in_valid by one cycle.
- Decoder:
  - Latency 2 cycles with dec_out_ready high; throughput 1 word/cycle.
  - A stage loads when it is empty or its contents are advancing. dec_in_ready = !s1_valid | s1_advance (combinational from dec_out_ready).
- Handshake rules:
  - While dec_out_valid=1 and dec_out_ready=0, all dec_out_* outputs hold stable.
  - Up to 2 words are buffered. After 2 stalled cycles dec_in_ready=0.
- Bypass is sampled into S1 per word. Changing it mid-stream affects only later words.
- Reset mid-operation: pipeline contents are discarded; no counts for in-flight words.

## Structure
- Package ecc_secded_pkg holds:
  - function calc_r(DATA_WIDTH);
  - the position-map function (data index to codeword position);
  - function ecc_secded_encode;
  - the error-class enum {CLEAN, SBIT_DATA, SBIT_CHK, DBIT}.
- Sub-module ecc_secded_syndrome: combinational; takes data and parity; outputs syndrome, correction mask and error class. It is instantiated once between S1 and S2.

## Test plan
- DATA_WIDTH=64, encode 64'h0 with mask 0 -> enc_out_parity=8'h00 one cycle later. Decode it -> clean, no count change.
- Inject mask bit 0 (data[0], position 3) -> s_h=3, s_p=1; dec_out_data=0, sbit=1, sbit_cnt=1, err_log_syn=8'h83.
- Inject data[0] and data[1] (positions 3 and 5) -> s_h=6, s_p=0; dbit=1, dbit_cnt=1. A held sbit log is overwritten with dbit=1.
- Inject parity[7] only -> sbit=1, data unchanged. With bypass=1, the same word gives flags 0 and no count.
- Random words with dec_out_ready toggling 50% -> in-order, lossless output; counts match handshakes. dec_in_ready drops after 2 stalled words.
- CNT_WIDTH=4 with 20 sbit words -> sbit_cnt=4'hF. cnt_clr coinciding with an sbit handshake -> sbit_cnt=1.

Source files
------------

// File: rtl/ecc_secded_pkg.sv
`default_nettype none
// ==== ecc_secded_pkg : SECDED code geometry, encoder function, error classes ==== rev 1.0 ====
package ecc_secded_pkg;

  localparam int MAX_DW = 247;
  localparam int MAX_PW = 9;

  typedef enum logic [1:0] {
    CLEAN     = 2'd0,
    SBIT_DATA = 2'd1,
    SBIT_CHK  = 2'd2,
    DBIT      = 2'd3
  } err_class_t;

  function automatic bit is_pow2(input int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Smallest R with 2^R >= dw + R + 1; scanning downward leaves the smallest hit.
  function automatic int calc_r(input int dw);
    int r;
    r = 0;
    for (int k = 8; k >= 1; k--) begin
      if ((1 << k) >= dw + k + 1) r = k;
    end
    return r;
  endfunction

  function automatic int data_pos(input int idx);
    int pos;
    int n;
    pos = 0;
    n   = 0;
    for (int p = 3; p < 512; p++) begin
      if (!is_pow2(p)) begin
        if (n == idx && pos == 0) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  // Returns parity[R-1:0] in the low bits and the overall-parity bit at index R.
  function automatic logic [MAX_PW-1:0] ecc_secded_encode(input logic [MAX_DW-1:0] data,
                                                         input int dw);
    logic [MAX_PW-1:0] par;
    logic [7:0]        syn;
    logic              ov;
    int                pos;
    syn = '0;
    ov  = 1'b0;
    pos = 3;
    for (int i = 0; i < MAX_DW; i++) begin
      if (i < dw) begin
        if (data[i]) begin
          syn = syn ^ pos[7:0];
          ov  = ~ov;
        end
        pos++;
        if (is_pow2(pos)) pos++;
      end
    end
    par = MAX_PW'(syn);
    par[calc_r(dw)] = ov ^ (^syn);
    return par;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_secded_syndrome.sv
`default_nettype none
// ==== ecc_secded_syndrome : syndrome, correction mask and error class (combinational) ==== rev 1.0 ====
module ecc_secded_syndrome
  import ecc_secded_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int PARITY_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [PARITY_WIDTH-1:0] parity,
  output logic [PARITY_WIDTH-1:0] syndrome,
  output logic [DATA_WIDTH-1:0]   corr_mask,
  output err_class_t              err_class
);

  localparam int R        = PARITY_WIDTH - 1;
  localparam int LAST_POS = DATA_WIDTH + R;

  logic [MAX_PW-1:0]     recalc;
  logic [R-1:0]          s_h;
  logic                  s_p;
  logic [DATA_WIDTH-1:0] hit_mask;
  logic                  unused_recalc;

  assign recalc        = ecc_secded_encode(MAX_DW'(data), DATA_WIDTH);
  assign unused_recalc = ^(recalc >> R);
  assign s_h           = recalc[R-1:0] ^ parity[R-1:0];
  assign s_p           = (^data) ^ (^parity);
  assign syndrome      = {s_p, s_h};

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_hit
    assign hit_mask[i] = (s_h == R'(data_pos(i)));
  end

  always_comb begin
    err_class = CLEAN;
    corr_mask = '0;
    if (s_p) begin
      if ((s_h & (s_h - 1'b1)) == '0) begin
        err_class = SBIT_CHK;
      end else if (int'(s_h) > LAST_POS) begin
        err_class = DBIT;
      end else begin
        err_class = SBIT_DATA;
        corr_mask = hit_mask;
      end
    end else if (s_h != '0) begin
      err_class = DBIT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ecc_secded_pipe.sv
`default_nettype none
// ==== ecc_secded_pipe : registered SECDED encoder, 2-stage decoder, counters, error log ==== rev 1.0 ====
module ecc_secded_pipe
  import ecc_secded_pkg::*;
#(
  parameter  int DATA_WIDTH   = 64,
  parameter  int TAG_WIDTH    = 10,
  parameter  int CNT_WIDTH    = 16,
  localparam int PARITY_WIDTH = calc_r(DATA_WIDTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               bypass,
  input  logic                               enc_in_valid,
  input  logic [DATA_WIDTH-1:0]              enc_in_data,
  input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] enc_inj_mask,
  output logic                               enc_out_valid,
  output logic [DATA_WIDTH-1:0]              enc_out_data,
  output logic [PARITY_WIDTH-1:0]            enc_out_parity,
  input  logic                               dec_in_valid,
  output logic                               dec_in_ready,
  input  logic [DATA_WIDTH-1:0]              dec_in_data,
  input  logic [PARITY_WIDTH-1:0]            dec_in_parity,
  input  logic [TAG_WIDTH-1:0]               dec_in_tag,
  output logic                               dec_out_valid,
  input  logic                               dec_out_ready,
  output logic [DATA_WIDTH-1:0]              dec_out_data,
  output logic [TAG_WIDTH-1:0]               dec_out_tag,
  output logic                               dec_out_sbit,
  output logic                               dec_out_dbit,
  output logic [CNT_WIDTH-1:0]               sbit_cnt,
  output logic [CNT_WIDTH-1:0]               dbit_cnt,
  output logic                               err_log_valid,
  output logic                               err_log_dbit,
  output logic [TAG_WIDTH-1:0]               err_log_tag,
  output logic [PARITY_WIDTH-1:0]            err_log_syn,
  input  logic                               cnt_clr
);

  logic [MAX_PW-1:0] enc_full;
  logic              unused_enc;

  assign enc_full   = ecc_secded_encode(MAX_DW'(enc_in_data), DATA_WIDTH);
  assign unused_enc = ^(enc_full >> PARITY_WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_out_valid  <= 1'b0;
      enc_out_data   <= '0;
      enc_out_parity <= '0;
    end else begin
      enc_out_valid <= enc_in_valid;
      if (enc_in_valid)
        {enc_out_parity, enc_out_data} <= {enc_full[PARITY_WIDTH-1:0], enc_in_data} ^ enc_inj_mask;
    end
  end

  logic                    s1_valid;
  logic                    s1_bypass;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [PARITY_WIDTH-1:0] s1_parity;
  logic [TAG_WIDTH-1:0]    s1_tag;
  logic                    s2_open;
  logic                    s1_load;

  // S2 can take a word when empty or when its word leaves this cycle.
  assign s2_open      = !dec_out_valid || dec_out_ready;
  assign dec_in_ready = !s1_valid || s2_open;
  assign s1_load      = dec_in_valid && dec_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_bypass <= 1'b0;
      s1_data   <= '0;
      s1_parity <= '0;
      s1_tag    <= '0;
    end else begin
      if (dec_in_ready) s1_valid <= dec_in_valid;
      if (s1_load) begin
        s1_bypass <= bypass;
        s1_data   <= dec_in_data;
        s1_parity <= dec_in_parity;
        s1_tag    <= dec_in_tag;
      end
    end
  end

  logic [PARITY_WIDTH-1:0] s1_syn;
  logic [DATA_WIDTH-1:0]   s1_mask;
  err_class_t              s1_class;

  ecc_secded_syndrome #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PARITY_WIDTH (PARITY_WIDTH)
  ) u_syndrome (
    .data      (s1_data),
    .parity    (s1_parity),
    .syndrome  (s1_syn),
    .corr_mask (s1_mask),
    .err_class (s1_class)
  );

  logic                    s2_bypass;
  logic [PARITY_WIDTH-1:0] s2_syn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_out_valid <= 1'b0;
      dec_out_data  <= '0;
      dec_out_tag   <= '0;
      dec_out_sbit  <= 1'b0;
      dec_out_dbit  <= 1'b0;
      s2_bypass     <= 1'b0;
      s2_syn        <= '0;
    end else if (s2_open) begin
      dec_out_valid <= s1_valid;
      if (s1_valid) begin
        dec_out_data <= s1_bypass ? s1_data : (s1_data ^ s1_mask);
        dec_out_tag  <= s1_tag;
        dec_out_sbit <= !s1_bypass && (s1_class == SBIT_DATA || s1_class == SBIT_CHK);
        dec_out_dbit <= !s1_bypass && (s1_class == DBIT);
        s2_bypass    <= s1_bypass;
        s2_syn       <= s1_syn;
      end
    end
  end

  logic out_fire;
  logic sbit_evt;
  logic dbit_evt;
  logic log_held;
  logic log_held_dbit;
  logic log_load;

  // Events are taken only on the handshake so a stalled word is counted once.
  assign out_fire      = dec_out_valid && dec_out_ready && !s2_bypass;
  assign sbit_evt      = out_fire && dec_out_sbit;
  assign dbit_evt      = out_fire && dec_out_dbit;
  assign log_held      = err_log_valid && !cnt_clr;
  assign log_held_dbit = err_log_dbit && !cnt_clr;
  assign log_load      = (sbit_evt || dbit_evt) && (!log_held || (dbit_evt && !log_held_dbit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt      <= '0;
      dbit_cnt      <= '0;
      err_log_valid <= 1'b0;
      err_log_dbit  <= 1'b0;
      err_log_tag   <= '0;
      err_log_syn   <= '0;
    end else begin
      if (cnt_clr)                           sbit_cnt <= CNT_WIDTH'(sbit_evt);
      else if (sbit_evt && sbit_cnt != '1)   sbit_cnt <= sbit_cnt + 1'b1;

      if (cnt_clr)                           dbit_cnt <= CNT_WIDTH'(dbit_evt);
      else if (dbit_evt && dbit_cnt != '1)   dbit_cnt <= dbit_cnt + 1'b1;

      if (log_load) begin
        err_log_valid <= 1'b1;
        err_log_dbit  <= dbit_evt;
        err_log_tag   <= dec_out_tag;
        err_log_syn   <= s2_syn;
      end else if (cnt_clr) begin
        err_log_valid <= 1'b0;
        err_log_dbit  <= 1'b0;
        err_log_tag   <= '0;
        err_log_syn   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ecc_secded_pipe.sv
`default_nettype none
// ==== tb_ecc_secded_pipe : directed checks of encoder, decoder, counters and log ==== rev 1.0 ====
module tb_ecc_secded_pipe;

  localparam int DW = 64;
  localparam int TW = 10;
  localparam int CW = 4;
  localparam int PW = 8;
  localparam int NR = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bypass = 1'b0;
  logic          enc_in_valid = 1'b0;
  logic [DW-1:0] enc_in_data = '0;
  logic [DW+PW-1:0] enc_inj_mask = '0;
  logic          enc_out_valid;
  logic [DW-1:0] enc_out_data;
  logic [PW-1:0] enc_out_parity;
  logic          dec_in_valid = 1'b0;
  logic          dec_in_ready;
  logic [DW-1:0] dec_in_data = '0;
  logic [PW-1:0] dec_in_parity = '0;
  logic [TW-1:0] dec_in_tag = '0;
  logic          dec_out_valid;
  logic          dec_out_ready = 1'b1;
  logic [DW-1:0] dec_out_data;
  logic [TW-1:0] dec_out_tag;
  logic          dec_out_sbit, dec_out_dbit;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic          err_log_valid, err_log_dbit;
  logic [TW-1:0] err_log_tag;
  logic [PW-1:0] err_log_syn;
  logic          cnt_clr = 1'b0;

  always #5 clk = ~clk;

  ecc_secded_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bypass(bypass),
    .enc_in_valid(enc_in_valid), .enc_in_data(enc_in_data), .enc_inj_mask(enc_inj_mask),
    .enc_out_valid(enc_out_valid), .enc_out_data(enc_out_data), .enc_out_parity(enc_out_parity),
    .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready), .dec_in_data(dec_in_data),
    .dec_in_parity(dec_in_parity), .dec_in_tag(dec_in_tag),
    .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready), .dec_out_data(dec_out_data),
    .dec_out_tag(dec_out_tag), .dec_out_sbit(dec_out_sbit), .dec_out_dbit(dec_out_dbit),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .err_log_valid(err_log_valid), .err_log_dbit(err_log_dbit),
    .err_log_tag(err_log_tag), .err_log_syn(err_log_syn), .cnt_clr(cnt_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: walk codeword positions, folding each set data bit's position in.
  function automatic logic [7:0] model_parity(input logic [63:0] d);
    logic [6:0] syn;
    logic       ov;
    int         k;
    syn = '0; ov = 1'b0; k = 0;
    for (int p = 1; p <= 71; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) begin syn = syn ^ 7'(p); ov = ~ov; end
        k++;
      end
    end
    return {ov ^ (^syn), syn};
  endfunction

  task automatic enc_one(input logic [63:0] d, input logic [71:0] m,
                         input logic [63:0] exp_d, input logic [7:0] exp_p, input string nm);
    enc_in_valid = 1'b1; enc_in_data = d; enc_inj_mask = m;
    @(posedge clk); #1;
    enc_in_valid = 1'b0;
    check({nm, "_valid"}, enc_out_valid, 1'b1);
    check({nm, "_data"}, enc_out_data, exp_d);
    check({nm, "_par"}, enc_out_parity, exp_p);
  endtask

  logic [63:0] o_data;
  logic        o_sb, o_db;
  logic [9:0]  o_tag;

  task automatic dec_one(input logic [63:0] d, input logic [7:0] p, input logic [9:0] t,
                         input logic clr);
    dec_in_valid = 1'b1; dec_in_data = d; dec_in_parity = p; dec_in_tag = t;
    @(posedge clk); #1;
    dec_in_valid = 1'b0;
    check("dec_lat_early", dec_out_valid, 1'b0);
    @(posedge clk); #1;
    check("dec_lat_valid", dec_out_valid, 1'b1);
    o_data = dec_out_data; o_sb = dec_out_sbit; o_db = dec_out_dbit; o_tag = dec_out_tag;
    cnt_clr = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  logic [63:0] rd [NR];
  logic [63:0] xw;
  logic        acc;
  int          rcv;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_enc_valid", enc_out_valid, 1'b0);
    check("rst_dec_ready", dec_in_ready, 1'b1);
    check("rst_dec_valid", dec_out_valid, 1'b0);
    check("rst_cnts", {sbit_cnt, dbit_cnt}, 8'h00);
    check("rst_log", {err_log_valid, err_log_syn, err_log_tag}, 19'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    enc_one(64'h0, 72'h0, 64'h0, 8'h00, "enc_zero");
    enc_one(64'h1, 72'h0, 64'h1, 8'h83, "enc_d0");
    enc_one(64'h3, 72'h0, 64'h3, 8'h06, "enc_d01");
    enc_one(64'h8000_0000_0000_0000, 72'h0, 64'h8000_0000_0000_0000, 8'hC7, "enc_d63");
    enc_one(64'h0, 72'h1, 64'h1, 8'h00, "enc_inj_d0");
    enc_one(64'h0, 72'h80_0000_0000_0000_0000, 64'h0, 8'h80, "enc_inj_p7");
    @(posedge clk); #1;
    check("enc_valid_drop", enc_out_valid, 1'b0);

    dec_one(64'h0, 8'h00, 10'd4, 1'b0);
    check("clean_flags", {o_sb, o_db}, 2'b00);
    check("clean_data", o_data, 64'h0);
    check("clean_cnts", {sbit_cnt, dbit_cnt}, 8'h00);

    dec_one(64'h1, 8'h00, 10'd5, 1'b0);
    check("sb_data", o_data, 64'h0);
    check("sb_flags", {o_sb, o_db}, 2'b10);
    check("sb_cnt", sbit_cnt, 4'd1);
    check("sb_log", {err_log_valid, err_log_dbit, err_log_tag, err_log_syn}, {2'b10, 10'd5, 8'h83});

    dec_one(64'h3, 8'h00, 10'd6, 1'b0);
    check("db_data", o_data, 64'h3);
    check("db_flags", {o_sb, o_db}, 2'b01);
    check("db_cnt", dbit_cnt, 4'd1);
    check("db_log_ovr", {err_log_valid, err_log_dbit, err_log_tag, err_log_syn}, {2'b11, 10'd6, 8'h06});

    dec_one(64'h1, 8'h00, 10'd7, 1'b0);
    check("sb2_cnt", sbit_cnt, 4'd2);
    check("sb2_log_kept", err_log_tag, 10'd6);

    dec_one(64'h0, 8'h7F, 10'd8, 1'b0);
    check("db_hi_flags", {o_sb, o_db}, 2'b01);
    check("db_hi_cnt", dbit_cnt, 4'd2);
    check("db_hi_log_kept", {err_log_tag, err_log_syn}, {10'd6, 8'h06});

    xw = 64'hDEAD_BEEF_0123_4567;
    dec_one(xw, model_parity(xw) ^ 8'h80, 10'd9, 1'b0);
    check("p7_data", o_data, xw);
    check("p7_flags", {o_sb, o_db}, 2'b10);
    check("p7_cnt", sbit_cnt, 4'd3);

    bypass = 1'b1;
    dec_one(xw, model_parity(xw) ^ 8'h80, 10'd10, 1'b0);
    check("byp_flags", {o_sb, o_db}, 2'b00);
    check("byp_data", o_data, xw);
    dec_one(64'h1, 8'h00, 10'd11, 1'b0);
    check("byp_raw_data", o_data, 64'h1);
    check("byp_cnts", {sbit_cnt, dbit_cnt}, {4'd3, 4'd2});
    bypass = 1'b0;

    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_cnts", {sbit_cnt, dbit_cnt}, 8'h00);
    check("clr_log", err_log_valid, 1'b0);

    // Two-word stall: second word lands in S1, input side then closes.
    dec_out_ready = 1'b0;
    dec_in_valid = 1'b1; dec_in_data = 64'h11; dec_in_parity = model_parity(64'h11); dec_in_tag = 10'd20;
    @(posedge clk); #1;
    check("stall_ready1", dec_in_ready, 1'b1);
    dec_in_data = 64'h22; dec_in_parity = model_parity(64'h22); dec_in_tag = 10'd21;
    @(posedge clk); #1;
    dec_in_valid = 1'b0;
    check("stall_ready0", dec_in_ready, 1'b0);
    check("stall_out_tag", dec_out_tag, 10'd20);
    @(posedge clk); #1;
    check("stall_hold", {dec_out_valid, dec_out_tag, dec_out_data}, {1'b1, 10'd20, 64'h11});
    dec_out_ready = 1'b1;
    #1;
    check("stall_ready_comb", dec_in_ready, 1'b1);
    @(posedge clk); #1;
    check("stall_second", {dec_out_valid, dec_out_tag, dec_out_data}, {1'b1, 10'd21, 64'h22});
    @(posedge clk); #1;
    check("stall_drain", dec_out_valid, 1'b0);

    // Streaming with random output backpressure; every third word has one data bit flipped.
    for (int i = 0; i < NR; i++) rd[i] = {$urandom(), $urandom()};
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    fork
      begin : prod
        int guard;
        guard = 0;
        for (int i = 0; i < NR; i++) begin
          dec_in_valid  = 1'b1;
          dec_in_data   = rd[i] ^ ((i % 3 == 0) ? (64'd1 << (i % 64)) : 64'd0);
          dec_in_parity = model_parity(rd[i]);
          dec_in_tag    = 10'(i);
          acc = 1'b0;
          while (!acc && guard < 2000) begin
            @(negedge clk);
            acc = dec_in_ready;
            @(posedge clk); #1;
            guard++;
          end
        end
        dec_in_valid = 1'b0;
      end
      begin : cons
        int cyc;
        cyc = 0;
        rcv = 0;
        while (rcv < NR && cyc < 2000) begin
          dec_out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (dec_out_valid && dec_out_ready) begin
            check("rand_tag", dec_out_tag, 10'(rcv));
            check("rand_data", dec_out_data, rd[rcv]);
            rcv++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        dec_out_ready = 1'b1;
      end
    join
    check("rand_words", rcv, NR);
    check("rand_sbit_cnt", sbit_cnt, 4'd8);
    check("rand_dbit_cnt", dbit_cnt, 4'd0);

    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) dec_one(64'h1, 8'h00, 10'(i), 1'b0);
    check("sat_cnt", sbit_cnt, 4'hF);

    dec_one(64'h1, 8'h00, 10'd99, 1'b1);
    check("clr_coll_cnt", sbit_cnt, 4'd1);
    check("clr_coll_log", {err_log_valid, err_log_dbit, err_log_tag, err_log_syn}, {2'b10, 10'd99, 8'h83});

    // Reset with a word in flight: it must vanish without being counted.
    dec_in_valid = 1'b1; dec_in_data = 64'h3; dec_in_parity = 8'h00; dec_in_tag = 10'd50;
    @(posedge clk); #1;
    dec_in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", dec_out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_drop", {dec_out_valid, sbit_cnt, dbit_cnt, err_log_valid}, 10'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
